gmii_tx_framer: RTL and testbench

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

---
 rtl/gmii_tx_framer.sv | 206 ++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, data with zero padding,
// CRC-32 FCS, inter-frame gap, and underrun abort with drain.
module gmii_tx_framer #(
   parameter int unsigned MIN_LEN = 60,
   parameter int unsigned IFG     = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] fifo_rd_data,
   input  logic       fifo_empty,
   output logic       fifo_rd_en,
   input  logic       frm_rdy,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       busy,
   output logic       tx_done,
   output logic       underrun
);

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SFD,
      DATA,
      PAD,
      FCS,
      DRAIN,
      GAP
   } state_t;

   localparam logic [15:0] MIN_W    = 16'(MIN_LEN);
   localparam logic [7:0]  IFG_LAST = 8'(IFG - 1);
   localparam logic [7:0]  PRE_LAST = 8'd5;
   localparam logic [31:0] POLY     = 32'hEDB88320;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic [15:0] cnt_inc;
   logic [7:0]  sub_q;
   logic [7:0]  sub_d;
   logic [31:0] crc_q;
   logic [31:0] crc_d;
   logic [31:0] fcs;
   logic [7:0]  fcs_byte;
   logic [7:0]  in_byte;
   logic        in_last;
   logic [7:0]  txd_d;
   logic        en_d;
   logic        er_d;
   logic        done_d;
   logic        und_d;

   function automatic logic [31:0] crc_step(
      input logic [31:0] c,
      input logic [7:0]  b
   );
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      end
      return r;
   endfunction

   assign in_byte = fifo_rd_data[7:0];
   assign in_last = fifo_rd_data[8];
   assign busy    = (state_q != IDLE);
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
   assign fcs     = ~crc_q;

   always_comb begin
      fcs_byte = fcs[7:0];
      unique case (sub_q[1:0])
         2'd0: fcs_byte = fcs[7:0];
         2'd1: fcs_byte = fcs[15:8];
         2'd2: fcs_byte = fcs[23:16];
         2'd3: fcs_byte = fcs[31:24];
      endcase
   end

   // Outputs are registered: each edge emits the byte belonging to the
   // state being left, so the wire stream runs without bubbles.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sub_d      = sub_q;
      crc_d      = crc_q;
      txd_d      = 8'h00;
      en_d       = 1'b0;
      er_d       = 1'b0;
      done_d     = 1'b0;
      und_d      = 1'b0;
      fifo_rd_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frm_rdy && !fifo_empty) begin
               state_d = PRE;
               sub_d   = 8'd0;
               cnt_d   = 16'd0;
               en_d    = 1'b1;
               txd_d   = 8'h55;
            end
         end
         PRE: begin
            en_d  = 1'b1;
            txd_d = 8'h55;
            if (sub_q == PRE_LAST) begin
               state_d = SFD;
               sub_d   = 8'd0;
            end else begin
               sub_d = sub_q + 8'd1;
            end
         end
         SFD: begin
            en_d    = 1'b1;
            txd_d   = 8'hD5;
            crc_d   = 32'hFFFF_FFFF;
            cnt_d   = 16'd0;
            state_d = DATA;
         end
         DATA: begin
            en_d = 1'b1;
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               txd_d      = in_byte;
               crc_d      = crc_step(crc_q, in_byte);
               cnt_d      = cnt_inc;
               if (in_last) begin
                  sub_d   = 8'd0;
                  state_d = (cnt_inc < MIN_W) ? PAD : FCS;
               end
            end else begin
               er_d    = 1'b1;
               und_d   = 1'b1;
               state_d = DRAIN;
            end
         end
         PAD: begin
            en_d  = 1'b1;
            crc_d = crc_step(crc_q, 8'h00);
            cnt_d = cnt_inc;
            if (cnt_inc >= MIN_W) begin
               sub_d   = 8'd0;
               state_d = FCS;
            end
         end
         FCS: begin
            en_d  = 1'b1;
            txd_d = fcs_byte;
            if (sub_q[1:0] == 2'd3) begin
               done_d  = 1'b1;
               sub_d   = 8'd0;
               state_d = GAP;
            end else begin
               sub_d = sub_q + 8'd1;
            end
         end
         DRAIN: begin
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               if (in_last) begin
                  sub_d   = 8'd0;
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (sub_q == IFG_LAST) begin
               sub_d   = 8'd0;
               state_d = IDLE;
            end else begin
               sub_d = sub_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 16'd0;
         sub_q      <= 8'd0;
         crc_q      <= 32'hFFFF_FFFF;
         gmii_txd   <= 8'h00;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         tx_done    <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sub_q      <= sub_d;
         crc_q      <= crc_d;
         gmii_txd   <= txd_d;
         gmii_tx_en <= en_d;
         gmii_tx_er <= er_d;
         tx_done    <= done_d;
         underrun   <= und_d;
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: frame-level model of the wire stream
// compared every cycle, plus literal checks on lengths, gaps and FCS.
module tb_gmii_tx_framer;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [8:0] a_rd_data, b_rd_data;
   logic       a_empty, b_empty, a_rd_en, b_rd_en;
   logic       a_frm_rdy, b_frm_rdy;
   logic [7:0] a_txd, b_txd;
   logic       a_en, a_er, a_busy, a_done, a_und;
   logic       b_en, b_er, b_busy, b_done, b_und;

   gmii_tx_framer #(.MIN_LEN(1), .IFG(12)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .fifo_rd_data(a_rd_data), .fifo_empty(a_empty),
      .fifo_rd_en(a_rd_en), .frm_rdy(a_frm_rdy),
      .gmii_txd(a_txd), .gmii_tx_en(a_en), .gmii_tx_er(a_er),
      .busy(a_busy), .tx_done(a_done), .underrun(a_und)
   );

   gmii_tx_framer #(.MIN_LEN(60), .IFG(12)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .fifo_rd_data(b_rd_data), .fifo_empty(b_empty),
      .fifo_rd_en(b_rd_en), .frm_rdy(b_frm_rdy),
      .gmii_txd(b_txd), .gmii_tx_en(b_en), .gmii_tx_er(b_er),
      .busy(b_busy), .tx_done(b_done), .underrun(b_und)
   );

   int checks = 0;
   int errors = 0;

   logic [8:0] qa[$];
   logic [8:0] qb[$];
   logic [9:0] expa[$];
   logic [9:0] expb[$];
   int   lasts_a = 0, lasts_b = 0;
   logic a_hold = 0, b_hold = 0, a_force = 0, b_force = 0;
   int   pops_a = 0, pops_b = 0;
   int   en_cnt_a = 0, en_cnt_b = 0, und_b = 0;
   logic [31:0] a_last4 = 0;
   logic [7:0]  a_done_byte = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic refresh();
      a_empty   = (qa.size() == 0) || a_hold;
      b_empty   = (qb.size() == 0) || b_hold;
      a_rd_data = (qa.size() != 0) ? qa[0] : 9'd0;
      b_rd_data = (qb.size() != 0) ? qb[0] : 9'd0;
      a_frm_rdy = (lasts_a > 0) || a_force;
      b_frm_rdy = (lasts_b > 0) || b_force;
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0] b);
      logic [31:0] r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
         else r = r >> 1;
      end
      return r;
   endfunction

   task automatic pushe(input bit to_a, input logic [9:0] v);
      if (to_a) expa.push_back(v);
      else expb.push_back(v);
   endtask

   // Queue one frame upstream and its expected wire image.
   task automatic load(input bit to_a, input int n, input int first,
                       input int min_len, input int abort_at);
      logic [7:0]  b;
      logic [31:0] c = 32'hFFFF_FFFF;
      for (int i = 0; i < 7; i++) pushe(to_a, 10'h055);
      pushe(to_a, 10'h0D5);
      for (int i = 0; i < n; i++) begin
         b = 8'(first + i);
         if (to_a) qa.push_back({i == n - 1, b});
         else qb.push_back({i == n - 1, b});
         if (abort_at < 0 || i < abort_at) begin
            pushe(to_a, {2'b00, b});
            c = crc_upd(c, b);
         end
      end
      if (to_a) lasts_a++;
      else lasts_b++;
      if (abort_at >= 0) begin
         pushe(to_a, 10'h100);
      end else begin
         for (int i = n; i < min_len; i++) begin
            pushe(to_a, 10'h000);
            c = crc_upd(c, 8'h00);
         end
         c = ~c;
         for (int k = 0; k < 4; k++) pushe(to_a, {k == 3, 1'b0, c[8*k +: 8]});
      end
      refresh();
   endtask

   always @(posedge clk) begin : popper
      logic pa, pb;
      pa = a_rd_en;
      pb = b_rd_en;
      #1;
      if (pa && qa.size() > 0) begin
         if (qa[0][8]) lasts_a--;
         void'(qa.pop_front());
         pops_a++;
      end
      if (pb && qb.size() > 0) begin
         if (qb[0][8]) lasts_b--;
         void'(qb.pop_front());
         pops_b++;
      end
      refresh();
   end

   always @(negedge clk) begin : cmp
      logic [9:0] e;
      if (rst_n) begin
         if (a_en) begin
            if (expa.size() == 0) chk("a_extra_en", 1, 0);
            else begin
               e = expa.pop_front();
               chk("a_stream", {a_done, a_er, a_txd}, e);
               chk("a_und", a_und, e[8]);
            end
         end else chk("a_quiet", {a_done, a_er, a_und, a_txd}, 0);
         if (b_en) begin
            if (expb.size() == 0) chk("b_extra_en", 1, 0);
            else begin
               e = expb.pop_front();
               chk("b_stream", {b_done, b_er, b_txd}, e);
               chk("b_und", b_und, e[8]);
            end
         end else chk("b_quiet", {b_done, b_er, b_und, b_txd}, 0);
      end
   end

   always @(negedge clk) begin
      if (a_en) begin
         en_cnt_a++;
         a_last4 = {a_txd, a_last4[31:8]};
      end
      if (a_done) a_done_byte = a_txd;
      if (b_en) en_cnt_b++;
      if (b_und) und_b++;
   end

   task automatic wait_done(input bit to_a, input int max);
      int n = 0;
      while (!(to_a ? a_busy : b_busy) && n < max) begin
         @(negedge clk);
         n++;
      end
      while ((to_a ? a_busy : b_busy) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(to_a ? "a_timeout" : "b_timeout", n >= max, 0);
      chk(to_a ? "a_exp_left" : "b_exp_left",
          to_a ? expa.size() : expb.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n, g;
      logic [31:0] c;
      refresh();
      #1 rst_n = 1'b0;
      #3;
      chk("rst_a", {a_en, a_er, a_done, a_und, a_busy, a_rd_en, a_txd}, 0);
      chk("rst_b", {b_en, b_er, b_done, b_und, b_busy, b_rd_en, b_txd}, 0);
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 9; i++) c = crc_upd(c, 8'(8'h31 + i));
      chk("model_crc", ~c, 32'hCBF43926);
      @(negedge clk);
      rst_n = 1'b1;

      // "123456789" with MIN_LEN=1
      @(negedge clk);
      en_cnt_a = 0;
      load(1, 9, 8'h31, 1, -1);
      wait_done(1, 200);
      chk("a_en_cycles", en_cnt_a, 21);
      chk("a_fcs_bytes", a_last4, 32'hCBF43926);
      chk("a_done_byte", a_done_byte, 8'hCB);
      chk("a_pops", pops_a, 9);

      // short frame padded to 60
      @(negedge clk);
      base = pops_b;
      en_cnt_b = 0;
      load(0, 10, 8'h10, 60, -1);
      wait_done(0, 400);
      chk("pad_en_cycles", en_cnt_b, 72);
      chk("pad_pops", pops_b - base, 10);

      // back-to-back 64-byte frames
      base = pops_b;
      load(0, 64, 8'h40, 60, -1);
      load(0, 64, 8'h80, 60, -1);
      n = 0;
      while (!b_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_first_done", n >= 500, 0);
      g = 0;
      @(negedge clk);
      while (!b_en && g < 100) begin
         g++;
         @(negedge clk);
      end
      chk("b2b_gap", g, 12);
      wait_done(0, 500);
      chk("b2b_pops", pops_b - base, 128);

      // underrun after data byte 5 of a 20-byte frame
      @(negedge clk);
      base = pops_b;
      und_b = 0;
      load(0, 20, 8'h20, 60, 5);
      n = 0;
      while (pops_b < base + 5 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      b_hold = 1'b1;
      refresh();
      chk("ur_pops5", pops_b - base, 5);
      repeat (4) @(negedge clk);
      b_hold = 1'b0;
      refresh();
      n = 0;
      while (pops_b < base + 20 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("ur_pops20", pops_b - base, 20);
      g = 0;
      @(negedge clk);
      while (b_busy && g < 100) begin
         g++;
         @(negedge clk);
      end
      chk("ur_gap", g, 12);
      chk("ur_pulses", und_b, 1);
      chk("ur_exp_left", expb.size(), 0);

      // frm_rdy with empty fifo
      base = pops_b;
      b_force = 1'b1;
      refresh();
      repeat (10) @(negedge clk);
      chk("idle_busy", b_busy, 0);
      chk("idle_pops", pops_b - base, 0);
      b_force = 1'b0;
      refresh();

      // reset during FCS byte 2, then clean restart
      @(negedge clk);
      load(0, 64, 8'hC0, 60, -1);
      n = 0;
      while (!(b_en && expb.size() == 3) && n < 300) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("rst_fcs_reached", n >= 300, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out", {b_en, b_er, b_done, b_und, b_txd}, 0);
      chk("rst_mid_busy", b_busy, 0);
      qb.delete();
      expb.delete();
      lasts_b = 0;
      refresh();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      base = pops_b;
      load(0, 64, 8'h33, 60, -1);
      @(posedge clk);
      #1;
      chk("restart_en", {b_en, b_txd}, {1'b1, 8'h55});
      wait_done(0, 500);
      chk("restart_pops", pops_b - base, 64);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
